// File: rtl/ser_shift_core.sv
// rtl/ser_shift_core.sv - parallel-to-serial shifter with a one-word holding register
// Optional parity output is built only when SER_PARITY_EN is defined.
module ser_shift_core #(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_LVL = 1'b1,
  localparam int  CNT_W    = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DATA,
  input  logic             Data_Valid,
  output logic             Data_Ready,
  input  logic [CNT_W-1:0] Data_Len,
  input  logic             Msb_First,
  input  logic             Enable,
  input  logic             Par_Odd,
  output logic             Busy,
  output logic             ser_out,
  output logic             ser_done,
  output logic             Par_Bit
);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  logic [CNT_W-1:0] hold_len_q, hold_len_d;
  logic             hold_msb_q, hold_msb_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_done_q, ser_done_d;

  logic             accept;
  logic             load;
  logic [CNT_W-1:0] len_norm;
  logic [WIDTH-1:0] load_word;

  assign accept = Data_Valid && !hold_full_q;

  always_comb begin
    len_norm = Data_Len;
    if (Data_Len == '0 || Data_Len > CNT_W'(WIDTH)) begin
      len_norm = CNT_W'(WIDTH);
    end
  end

  // Held word re-ordered so the first bit to send sits at bit 0; unused bits are zero.
  always_comb begin
    load_word = '0;
    if (hold_msb_q) begin
      for (int i = 0; i < WIDTH; i++) begin
        for (int j = 0; j < WIDTH; j++) begin
          if (i + j + 1 == int'(hold_len_q)) begin
            load_word[i] = hold_data_q[j];
          end
        end
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (i < int'(hold_len_q)) begin
          load_word[i] = hold_data_q[i];
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_len_d  = hold_len_q;
    hold_msb_d  = hold_msb_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    ser_out_d   = ser_out_q;
    ser_done_d  = 1'b0;
    load        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ser_out_d = IDLE_LVL;
        if (hold_full_q) begin
          load = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (Enable) begin
          if (cnt_q <= CNT_W'(1)) begin
            ser_done_d = 1'b1;
            if (hold_full_q) begin
              load = 1'b1;
            end else begin
              state_d   = ST_IDLE;
              ser_out_d = IDLE_LVL;
              cnt_d     = '0;
              shift_d   = '0;
            end
          end else begin
            ser_out_d = shift_q[0];
            shift_d   = shift_q >> 1;
            cnt_d     = cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (load) begin
      state_d     = ST_SHIFT;
      cnt_d       = hold_len_q;
      ser_out_d   = load_word[0];
      shift_d     = load_word >> 1;
      hold_full_d = 1'b0;
    end

    // accept and load are exclusive: accept needs an empty holding register, load a full one.
    if (accept) begin
      hold_full_d = 1'b1;
      hold_data_d = DATA;
      hold_len_d  = len_norm;
      hold_msb_d  = Msb_First;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      hold_data_q <= '0;
      hold_len_q  <= '0;
      hold_msb_q  <= 1'b0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      ser_out_q   <= IDLE_LVL;
      ser_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_len_q  <= hold_len_d;
      hold_msb_q  <= hold_msb_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      ser_out_q   <= ser_out_d;
      ser_done_q  <= ser_done_d;
    end
  end

  assign Data_Ready = !hold_full_q;
  assign Busy       = (state_q == ST_SHIFT);
  assign ser_out    = ser_out_q;
  assign ser_done   = ser_done_q;

`ifdef SER_PARITY_EN
  logic hold_odd_q, hold_odd_d;
  logic par_q, par_d;

  // load_word holds exactly the valid bits, so its reduction XOR is the word parity.
  always_comb begin
    hold_odd_d = accept ? Par_Odd : hold_odd_q;
    par_d      = load ? ((^load_word) ^ hold_odd_q) : par_q;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hold_odd_q <= 1'b0;
      par_q      <= 1'b0;
    end else begin
      hold_odd_q <= hold_odd_d;
      par_q      <= par_d;
    end
  end

  assign Par_Bit = par_q;
`else
  logic unused_par_odd;
  assign unused_par_odd = Par_Odd;
  assign Par_Bit        = 1'b0;
`endif

endmodule

// File: tb/tb_ser_shift_core.sv
// tb/tb_ser_shift_core.sv - directed vector bench for ser_shift_core (WIDTH=8, IDLE_LVL=1)
module tb_ser_shift_core;

  logic       CLK;
  logic       RST;
  logic [7:0] DATA;
  logic       Data_Valid;
  logic       Data_Ready;
  logic [3:0] Data_Len;
  logic       Msb_First;
  logic       Enable;
  logic       Par_Odd;
  logic       Busy;
  logic       ser_out;
  logic       ser_done;
  logic       Par_Bit;

  int n_vec = 0;
  int n_bad = 0;

  ser_shift_core #(.WIDTH(8), .IDLE_LVL(1'b1)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .DATA      (DATA),
    .Data_Valid(Data_Valid),
    .Data_Ready(Data_Ready),
    .Data_Len  (Data_Len),
    .Msb_First (Msb_First),
    .Enable    (Enable),
    .Par_Odd   (Par_Odd),
    .Busy      (Busy),
    .ser_out   (ser_out),
    .ser_done  (ser_done),
    .Par_Bit   (Par_Bit)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]  d;
    logic [3:0]  len;
    logic        msb;
    logic        odd;
    logic [15:0] bits;
    int          n;
    logic        par;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic exp_par(input logic p);
`ifdef SER_PARITY_EN
    return p;
`else
    return 1'b0;
`endif
  endfunction

  task automatic offer(input logic [7:0] d, input logic [3:0] len, input logic msb, input logic odd);
    bit got;
    got = 1'b0;
    DATA = d; Data_Len = len; Msb_First = msb; Par_Odd = odd; Data_Valid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      got = Data_Ready;
      @(negedge CLK);
    end
    Data_Valid = 1'b0;
    chk("accept_budget", 32'(got), 32'd1);
  endtask

  task automatic collect(input int period, input int words, output logic [15:0] bits,
                         output int n, output int dones, output int gaps);
    int  c;
    bit  started;
    bits = '0; n = 0; dones = 0; gaps = 0; started = 1'b0;
    for (c = 0; c < 400; c++) begin
      @(negedge CLK);
      if (ser_done) dones++;
      if (dones >= words && !Busy) break;
      if (Busy) started = 1'b1;
      else if (started) gaps++;
      Enable = (c % period == 0);
      if (Enable && Busy) begin
        bits = {bits[14:0], ser_out};
        n++;
      end
    end
    Enable = 1'b0;
    chk("cycle_budget", 32'(c < 400), 32'd1);
    @(negedge CLK);
    if (ser_done) dones++;
  endtask

  logic [15:0] bits;
  int          n, dones, gaps, bad_cnt;

  initial begin
    tbl[0] = '{8'hA5, 4'd8,  1'b0, 1'b0, 16'b10100101, 8, 1'b0};
    tbl[1] = '{8'h13, 4'd5,  1'b1, 1'b0, 16'b10011,    5, 1'b1};
    tbl[2] = '{8'h13, 4'd5,  1'b0, 1'b1, 16'b11001,    5, 1'b0};
    tbl[3] = '{8'hC3, 4'd0,  1'b0, 1'b1, 16'b11000011, 8, 1'b1};
    tbl[4] = '{8'h2D, 4'd15, 1'b1, 1'b0, 16'b00101101, 8, 1'b0};
    tbl[5] = '{8'hFE, 4'd3,  1'b1, 1'b1, 16'b110,      3, 1'b1};
    tbl[6] = '{8'h01, 4'd1,  1'b0, 1'b0, 16'b1,        1, 1'b1};
    tbl[7] = '{8'h07, 4'd8,  1'b0, 1'b0, 16'b11100000, 8, 1'b1};
    tbl[8] = '{8'h07, 4'd8,  1'b1, 1'b1, 16'b00000111, 8, 1'b0};

    RST = 1'b0; DATA = '0; Data_Valid = 1'b0; Data_Len = '0;
    Msb_First = 1'b0; Enable = 1'b0; Par_Odd = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_ready", 32'(Data_Ready), 32'd1);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_ser_out", 32'(ser_out), 32'd1);
    chk("rst_done", 32'(ser_done), 32'd0);
    chk("rst_par", 32'(Par_Bit), 32'd0);
    RST = 1'b1;
    @(negedge CLK);

    // First-bit latency: accept edge, load edge, then bit 0 visible.
    offer(8'h5A, 4'd8, 1'b0, 1'b0);
    chk("lat_busy_pre", 32'(Busy), 32'd0);
    chk("lat_ready_held", 32'(Data_Ready), 32'd0);
    chk("lat_out_pre", 32'(ser_out), 32'd1);
    @(negedge CLK);
    chk("lat_busy", 32'(Busy), 32'd1);
    chk("lat_first_bit", 32'(ser_out), 32'd0);
    collect(1, 1, bits, n, dones, gaps);
    chk("lat_bits", 32'(bits), 32'h5A);
    chk("lat_dones", 32'(dones), 32'd1);

    for (int v = 0; v < 9; v++) begin
      offer(tbl[v].d, tbl[v].len, tbl[v].msb, tbl[v].odd);
      collect(1, 1, bits, n, dones, gaps);
      chk($sformatf("v%0d_bits", v), 32'(bits), 32'(tbl[v].bits));
      chk($sformatf("v%0d_count", v), 32'(n), 32'(tbl[v].n));
      chk($sformatf("v%0d_done", v), 32'(dones), 32'd1);
      chk($sformatf("v%0d_busy_end", v), 32'(Busy), 32'd0);
      chk($sformatf("v%0d_par", v), 32'(Par_Bit), 32'(exp_par(tbl[v].par)));
    end

    // Enable in IDLE must do nothing.
    bad_cnt = 0;
    Enable = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      if (Busy || ser_done || ser_out !== 1'b1) bad_cnt++;
    end
    Enable = 1'b0;
    chk("idle_enable_ignored", 32'(bad_cnt), 32'd0);

    // Back-to-back words with a slow bit strobe: no gap between them.
    offer(8'hFF, 4'd8, 1'b0, 1'b0);
    offer(8'h00, 4'd8, 1'b0, 1'b0);
    chk("b2b_ready_held", 32'(Data_Ready), 32'd0);
    collect(4, 2, bits, n, dones, gaps);
    chk("b2b_bits", 32'(bits), 32'hFF00);
    chk("b2b_count", 32'(n), 32'd16);
    chk("b2b_dones", 32'(dones), 32'd2);
    chk("b2b_gaps", 32'(gaps), 32'd0);

    // Reset mid-word with a second word held.
    offer(8'h5A, 4'd8, 1'b0, 1'b0);
    offer(8'h3C, 4'd8, 1'b0, 1'b0);
    chk("rstmid_ready_held", 32'(Data_Ready), 32'd0);
    Enable = 1'b1;
    repeat (3) @(negedge CLK);
    Enable = 1'b0;
    chk("rstmid_bit3", 32'(ser_out), 32'd1);
    #2 RST = 1'b0;
    #1;
    chk("rstmid_busy", 32'(Busy), 32'd0);
    chk("rstmid_ser_out", 32'(ser_out), 32'd1);
    chk("rstmid_done", 32'(ser_done), 32'd0);
    chk("rstmid_ready", 32'(Data_Ready), 32'd1);
    chk("rstmid_par", 32'(Par_Bit), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    bad_cnt = 0;
    Enable = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      if (ser_done || Busy) bad_cnt++;
    end
    Enable = 1'b0;
    chk("rstmid_abandoned", 32'(bad_cnt), 32'd0);
    offer(8'hC3, 4'd8, 1'b1, 1'b0);
    collect(1, 1, bits, n, dones, gaps);
    chk("post_rst_bits", 32'(bits), 32'hC3);
    chk("post_rst_count", 32'(n), 32'd8);
    chk("post_rst_done", 32'(dones), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
